pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_pkg.sv | 12 +
 rtl/pipe_stall_ctrl_fwd_sel.sv | 32 +++
 rtl/pipe_stall_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline encodings: operand forwarding sources and stall FSM states.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXE   = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MDATA = 2'b11;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/pipe_stall_ctrl_fwd_sel.sv
// Forwarding source selector for one ID-stage source register.
module pipe_fwd_sel
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [4:0] rn,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] fwd
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ewreg & (ern != 5'd0) & (ern == rn);
  assign mem_hit = mwreg & (mrn != 5'd0) & (mrn == rn);

  // A load still in EX has no data yet; the load-use stall covers that case.
  always_comb begin
    fwd = FWD_RF;
    if (ex_hit && !em2reg)
      fwd = FWD_EXE;
    else if (mem_hit && mm2reg)
      fwd = FWD_MDATA;
    else if (mem_hit)
      fwd = FWD_MEM;
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and branch handling,
// and a memory wait FSM with timeout flag and stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             id_branch_taken,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic             dmem_ready,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_if,
  output logic             em_hold,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [0:0]    state;
  logic [0:0]    state_eff;
  logic [0:0]    state_next;
  logic [WW-1:0] wait_cnt;
  logic          mem_err_q;
  logic          in_wait;
  logic          mem_stall;
  logic          load_use;
  logic          err_hit;

  pipe_fwd_sel u_fwd_a (
    .rn(rs), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .fwd(fwda)
  );

  pipe_fwd_sel u_fwd_b (
    .rn(rt), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .fwd(fwdb)
  );

  // Held in reset the decode behaves as IDLE regardless of the stored state.
  assign state_eff = resetn ? state : ST_IDLE;
  assign in_wait   = (state_eff == ST_MEM_WAIT);
  assign mem_req   = in_wait | mm2reg | mwmem;
  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ewreg & em2reg & (ern != 5'd0) &
                     ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
  assign err_hit   = in_wait & (wait_cnt == WAIT_LAST);
  assign mem_err   = mem_err_q | err_hit;

  always_comb begin
    wpcir    = 1'b1;
    bubble   = 1'b0;
    flush_if = 1'b0;
    em_hold  = 1'b0;
    if (mem_stall) begin
      wpcir   = 1'b0;
      em_hold = 1'b1;
    end else if (load_use) begin
      wpcir  = 1'b0;
      bubble = 1'b1;
    end else if (id_branch_taken) begin
      flush_if = 1'b1;
    end
  end

  always_comb begin
    state_next = state_eff;
    if (!in_wait && mem_stall)
      state_next = ST_MEM_WAIT;
    else if (in_wait && dmem_ready)
      state_next = ST_IDLE;
  end

  // wait_cnt holds the number of completed MEM_WAIT cycles.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (!in_wait && mem_stall)
        wait_cnt <= '0;
      else if (in_wait && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (err_hit)
        mem_err_q <= 1'b1;
      if (!wpcir && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl with MAX_WAIT=4 and a 3-bit stall counter.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       wpcir;
    logic       bubble;
    logic       flush_if;
    logic       em_hold;
    logic       mem_req;
    logic       mem_err;
    logic [2:0] stall_cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] rs, rt, ern, mrn;
  logic       use_rs, use_rt, id_branch_taken;
  logic       ewreg, em2reg, mwreg, mm2reg, mwmem, dmem_ready;
  logic [1:0] fwda, fwdb;
  logic       wpcir, bubble, flush_if, em_hold, mem_req, mem_err;
  logic [2:0] stall_cnt;

  exp_t       expQ[$];
  logic [2:0] expCnt = 3'd0;
  int         compareCount = 0;
  int         mismatchCount = 0;

  always #5 clock = ~clock;

  pipe_stall_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .id_branch_taken(id_branch_taken),
    .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .dmem_ready(dmem_ready), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .bubble(bubble), .flush_if(flush_if), .em_hold(em_hold),
    .mem_req(mem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; id_branch_taken = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0; mwmem = 0; dmem_ready = 0;
  endtask

  // Inputs are already driven; push the expectation, compare mid-cycle, then advance.
  task automatic applyStimulus(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                               input logic w, input logic b, input logic f,
                               input logic h, input logic r, input logic e);
    exp_t x;
    x = '{fwda: fa, fwdb: fb, wpcir: w, bubble: b, flush_if: f,
          em_hold: h, mem_req: r, mem_err: e, stall_cnt: expCnt};
    expQ.push_back(x);
    #1;
    x = expQ.pop_front();
    checkOutput({tag, ".fwda"}, 32'(fwda), 32'(x.fwda));
    checkOutput({tag, ".fwdb"}, 32'(fwdb), 32'(x.fwdb));
    checkOutput({tag, ".wpcir"}, 32'(wpcir), 32'(x.wpcir));
    checkOutput({tag, ".bubble"}, 32'(bubble), 32'(x.bubble));
    checkOutput({tag, ".flush_if"}, 32'(flush_if), 32'(x.flush_if));
    checkOutput({tag, ".em_hold"}, 32'(em_hold), 32'(x.em_hold));
    checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'(x.mem_req));
    checkOutput({tag, ".mem_err"}, 32'(mem_err), 32'(x.mem_err));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(x.stall_cnt));
    @(posedge clock);
    if (!resetn) expCnt = 3'd0;
    else if (!w && expCnt != 3'd7) expCnt = expCnt + 3'd1;
    @(negedge clock);
  endtask

  initial begin
    clearInputs();
    resetn = 0;
    @(negedge clock);
    applyStimulus("reset0", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    resetn = 1;
    applyStimulus("idle", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);

    clearInputs(); ern = 5; ewreg = 1; rs = 5;
    applyStimulus("ex_fwd", 2'b01, 2'b00, 1, 0, 0, 0, 0, 0);
    clearInputs(); ern = 0; ewreg = 1; rs = 5;
    applyStimulus("ex_fwd_r0", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    clearInputs(); mrn = 7; mwreg = 1; rs = 7; rt = 7;
    applyStimulus("mem_alu", 2'b10, 2'b10, 1, 0, 0, 0, 0, 0);
    mm2reg = 1; dmem_ready = 1;
    applyStimulus("mem_load", 2'b11, 2'b11, 1, 0, 0, 0, 1, 0);
    clearInputs(); ern = 7; ewreg = 1; mrn = 7; mwreg = 1; rs = 7; rt = 2;
    applyStimulus("ex_over_mem", 2'b01, 2'b00, 1, 0, 0, 0, 0, 0);

    clearInputs(); ern = 3; ewreg = 1; em2reg = 1; use_rt = 1; rt = 3; id_branch_taken = 1;
    applyStimulus("load_use_br", 2'b00, 2'b00, 0, 1, 0, 0, 0, 0);
    clearInputs();
    applyStimulus("cnt_after_lu", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    ern = 3; ewreg = 1; em2reg = 1; rs = 3;
    applyStimulus("lu_rs_unused", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    clearInputs(); ewreg = 1; em2reg = 1; use_rs = 1;
    applyStimulus("lu_r0", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    clearInputs(); id_branch_taken = 1;
    applyStimulus("branch", 2'b00, 2'b00, 1, 0, 1, 0, 0, 0);

    clearInputs(); mwmem = 1; dmem_ready = 1;
    applyStimulus("store_zw", 2'b00, 2'b00, 1, 0, 0, 0, 1, 0);
    clearInputs();
    applyStimulus("store_idle", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);

    // Four not-ready cycles: the request cycle plus three MEM_WAIT cycles.
    mm2reg = 1;
    applyStimulus("mw_req", 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
    mm2reg = 0;
    for (int i = 0; i < 3; i++)
      applyStimulus("mw_wait", 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
    dmem_ready = 1;
    applyStimulus("mw_done", 2'b00, 2'b00, 1, 0, 0, 0, 1, 1);
    clearInputs();
    applyStimulus("mw_idle", 2'b00, 2'b00, 1, 0, 0, 0, 0, 1);
    resetn = 0;
    applyStimulus("mw_rst", 2'b00, 2'b00, 1, 0, 0, 0, 0, 1);
    resetn = 1;
    applyStimulus("post_rst", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);

    mm2reg = 1;
    applyStimulus("to_req", 2'b00, 2'b00, 0, 0, 0, 1, 1, 0);
    mm2reg = 0;
    for (int i = 1; i <= 7; i++)
      applyStimulus(i < 4 ? "to_wait_pre" : "to_wait_err", 2'b00, 2'b00, 0, 0, 0, 1, 1, i >= 4);
    dmem_ready = 1;
    applyStimulus("to_ready", 2'b00, 2'b00, 1, 0, 0, 0, 1, 1);
    clearInputs();
    applyStimulus("to_idle", 2'b00, 2'b00, 1, 0, 0, 0, 0, 1);

    mm2reg = 1;
    applyStimulus("rw_req", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1);
    mm2reg = 0;
    applyStimulus("rw_mw1", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1);
    resetn = 0;
    applyStimulus("rw_rst", 2'b00, 2'b00, 1, 0, 0, 0, 0, 1);
    resetn = 1;
    applyStimulus("rw_after", 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
